// File: rtl/mult_datapath.sv
// Sequential 8x8 unsigned multiplier datapath: one HALF_W x HALF_W multiplier
// accumulates four shifted partial products into a 4*HALF_W-bit product register.
module mult_datapath #(
  parameter int HALF_W = 4
) (
  input  logic                clk,
  input  logic                reset_a,
  input  logic [2*HALF_W-1:0] dataa,
  input  logic [2*HALF_W-1:0] datab,
  input  logic [1:0]          input_sel,
  input  logic [1:0]          shift_sel,
  input  logic                clk_ena,
  input  logic                sclr_n,
  output logic [1:0]          count,
  output logic [4*HALF_W-1:0] product,
  output logic                ovf
);

  localparam int PW = 2 * HALF_W;
  localparam int RW = 4 * HALF_W;

  logic [HALF_W-1:0] nib_a;
  logic [HALF_W-1:0] nib_b;
  logic [PW-1:0]     pp;
  logic [RW-1:0]     sh;
  logic [RW:0]       sum;

  logic [1:0]    count_d,   count_q;
  logic [RW-1:0] product_d, product_q;
  logic          ovf_d,     ovf_q;

  always_comb begin
    nib_a = input_sel[1] ? dataa[PW-1:HALF_W] : dataa[HALF_W-1:0];
    nib_b = input_sel[0] ? datab[PW-1:HALF_W] : datab[HALF_W-1:0];
    pp    = PW'(nib_a) * PW'(nib_b);
    case (shift_sel)
      2'b01:   sh = RW'(pp) << HALF_W;
      2'b10:   sh = RW'(pp) << (2 * HALF_W);
      default: sh = RW'(pp);
    endcase
    sum = {1'b0, product_q} + {1'b0, sh};
  end

  // Clear beats enable; when neither applies the selects are ignored entirely,
  // so X driven by the controller outside its calc states never reaches a flop.
  always_comb begin
    count_d   = count_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    if (!sclr_n) begin
      count_d   = 2'd0;
      product_d = '0;
      ovf_d     = 1'b0;
    end else if (clk_ena) begin
      count_d   = count_q + 2'd1;
      product_d = sum[RW-1:0];
      ovf_d     = ovf_q | sum[RW];
    end
  end

  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      count_q   <= 2'd0;
      product_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

  assign count   = count_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule
